// File: rtl/cx_types_pkg.sv
// -----------------------------------------------------------------------------
// cx_types_pkg
//   Shared complex-datapath types for the PFB chain.
//   - phase_t          : signed twiddle word (PHASE_WIDTH bits, PHASE_FRAC_WIDTH
//                        fraction bits) consumed on the mult-add B ports.
//   - phase_idx_t      : bin / phase index sized from the default PFB FFT length.
//   - round_half_away  : elaboration-time helper used to quantise $cos/$sin
//                        constants into ROM words.
// -----------------------------------------------------------------------------
package cx_types_pkg;

    localparam int PHASE_WIDTH      = 16;
    localparam int PHASE_FRAC_WIDTH = 15;

    typedef logic signed [PHASE_WIDTH-1:0] phase_t;

    localparam int PFB_FFT_LEN = 64;

    typedef logic [$clog2(PFB_FFT_LEN)-1:0] phase_idx_t;

    localparam real PHASE_PI = 3.141592653589793;

    // Round to nearest, ties away from zero (symmetric, so round(-x) == -round(x)).
    function automatic longint round_half_away(input real x);
        real r;
        if (x >= 0.0) begin
            r = $floor(x + 0.5);
        end else begin
            r = $ceil(x - 0.5);
        end
        return longint'($rtoi(r));
    endfunction

endpackage

// File: rtl/phase_rotation_gen_lut_rom.sv
// -----------------------------------------------------------------------------
// phase_lut_rom
//   Registered-read twiddle ROM. Returns br = cos(2*pi*p/N) and
//   bi = -sin(2*pi*p/N) one cycle after addr_i is presented with rd_en_i high.
//   Table contents are built at elaboration from $cos/$sin and quantised with
//   round-half-away, then saturated to the signed W-bit range.
//
//   Build option QUARTER_WAVE_ROM_EN:
//     defined     - only N/4+1 unsaturated cos entries are stored; the other
//                   quadrants and the sine come from index reflection and
//                   negation, saturated after negation so the result is
//                   bit-identical to the full-table build.
//     not defined - full N-entry cos and -sin tables.
//
//   Ports
//     clk       in   clock, rising edge
//     rd_en_i   in   read enable (pipeline advance)
//     addr_i    in   phase index p, $clog2(N) bits
//     br_o      out  W-bit cos word (valid one cycle after the read)
//     bi_o      out  W-bit -sin word
// -----------------------------------------------------------------------------
module phase_lut_rom
    import cx_types_pkg::*;
#(
    parameter int N = 64,
    parameter int W = PHASE_WIDTH,
    parameter int F = PHASE_FRAC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rd_en_i,
    input  logic [$clog2(N)-1:0] addr_i,
    output logic [W-1:0]         br_o,
    output logic [W-1:0]         bi_o
);

    localparam int  IW    = $clog2(N);
    // Two guard bits: +1.0 rounds to 2^(W-1) and its negation must not wrap.
    localparam int  RW    = W + 2;
    localparam real SCALE = 2.0 ** F;

    localparam logic signed [RW-1:0] SAT_HI = RW'((64'sd1 <<< (W - 1)) - 64'sd1);
    localparam logic signed [RW-1:0] SAT_LO = RW'(-(64'sd1 <<< (W - 1)));

    function automatic logic [W-1:0] sat_w(input logic signed [RW-1:0] v);
        if (v > SAT_HI) begin
            return SAT_HI[W-1:0];
        end else if (v < SAT_LO) begin
            return SAT_LO[W-1:0];
        end
        return v[W-1:0];
    endfunction

    genvar gi;

`ifdef QUARTER_WAVE_ROM_EN

    localparam int Q = N / 4;

    logic signed [RW-1:0] cosq [0:Q];

    generate
        for (gi = 0; gi <= Q; gi++) begin : g_quarter
            assign cosq[gi] = RW'(round_half_away(
                $cos(2.0 * PHASE_PI * real'(gi) / real'(N)) * SCALE));
        end
    endgenerate

    logic [1:0]           quad;
    logic [IW-2:0]        ra;     // angle offset within the quadrant
    logic [IW-2:0]        rb;     // reflected offset, Q - ra
    logic signed [RW-1:0] a_q;    // cos(r)
    logic signed [RW-1:0] b_q;    // cos(Q - r) == sin(r)
    logic [1:0]           quad_q;
    logic signed [RW-1:0] cr;
    logic signed [RW-1:0] ci;

    assign quad = addr_i[IW-1:IW-2];
    assign ra   = {1'b0, addr_i[IW-3:0]};
    assign rb   = (IW-1)'(Q) - ra;

    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            a_q    <= cosq[ra];
            b_q    <= cosq[rb];
            quad_q <= quad;
        end
    end

    // Quadrant unfolding: with theta = 2*pi*r/N,
    //   q0: cos= cos t, -sin=-sin t    q1: cos=-sin t, -sin=-cos t
    //   q2: cos=-cos t, -sin= sin t    q3: cos= sin t, -sin= cos t
    always_comb begin
        cr = a_q;
        ci = -b_q;
        case (quad_q)
            2'd0: begin cr =  a_q; ci = -b_q; end
            2'd1: begin cr = -b_q; ci = -a_q; end
            2'd2: begin cr = -a_q; ci =  b_q; end
            default: begin cr = b_q; ci = a_q; end
        endcase
    end

    assign br_o = sat_w(cr);
    assign bi_o = sat_w(ci);

`else

    logic [W-1:0] cos_tbl [0:N-1];
    logic [W-1:0] sin_tbl [0:N-1];
    logic [W-1:0] br_q;
    logic [W-1:0] bi_q;

    generate
        for (gi = 0; gi < N; gi++) begin : g_full
            assign cos_tbl[gi] = sat_w(RW'(round_half_away(
                $cos(2.0 * PHASE_PI * real'(gi) / real'(N)) * SCALE)));
            assign sin_tbl[gi] = sat_w(RW'(round_half_away(
                -$sin(2.0 * PHASE_PI * real'(gi) / real'(N)) * SCALE)));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            br_q <= cos_tbl[addr_i];
            bi_q <= sin_tbl[addr_i];
        end
    end

    assign br_o = br_q;
    assign bi_o = bi_q;

`endif

endmodule

// File: rtl/phase_rotation_gen.sv
// -----------------------------------------------------------------------------
// phase_rotation_gen
//   Streams the PFB phase-correction twiddle B = exp(-j*2*pi*p/N) with
//   p = (k*m*D) mod N for bin k of frame m, valid/ready backpressured.
//   p is produced by accumulators only: step = (m*D) mod N is added once per
//   bin, and step itself advances by D at each frame end.
//   Three-stage pipeline: S0 index issue, S1 registered ROM read, S2 output
//   register, all advancing together when the output is empty or accepted.
//   Build option QUARTER_WAVE_ROM_EN selects the quarter-wave ROM inside
//   phase_lut_rom; outputs and timing are identical either way.
//
//   Ports
//     clk          in   clock, rising edge
//     rst          in   asynchronous active-high reset
//     en           in   run request, sampled only when bin 0 is about to issue
//     phase_ready  in   downstream accepts the current word
//     phase_valid  out  br/bi/phase_last/bin_idx valid
//     br           out  cos(2*pi*p/N), PHASE_W bits
//     bi           out  -sin(2*pi*p/N), PHASE_W bits
//     phase_last   out  high on bin N-1
//     bin_idx      out  bin k of the current word
// -----------------------------------------------------------------------------
module phase_rotation_gen
    import cx_types_pkg::*;
#(
    parameter int FFT_LEN = PFB_FFT_LEN,
    parameter int DEC_FAC = 48,
    parameter int PHASE_W = PHASE_WIDTH,
    parameter int PHASE_F = PHASE_FRAC_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       phase_ready,
    output logic                       phase_valid,
    output logic [PHASE_W-1:0]         br,
    output logic [PHASE_W-1:0]         bi,
    output logic                       phase_last,
    output logic [$clog2(FFT_LEN)-1:0] bin_idx
);

    localparam int            IW     = $clog2(FFT_LEN);
    localparam logic [IW-1:0] K_LAST = IW'(FFT_LEN - 1);
    localparam logic [IW-1:0] D_STEP = IW'(DEC_FAC);

    logic          adv;
    logic          issue;
    logic [IW-1:0] k_q, k_d;
    logic [IW-1:0] p_q, p_d;
    logic [IW-1:0] step_q, step_d;
    logic          s0_valid_q;
    logic [IW-1:0] s0_k_q;
    logic [IW-1:0] s0_p_q;
    logic          s1_valid_q;
    logic [IW-1:0] s1_k_q;
    logic          valid_q;
    logic          last_q;
    logic [IW-1:0] idx_q;
    logic [PHASE_W-1:0] br_q;
    logic [PHASE_W-1:0] bi_q;
    logic [PHASE_W-1:0] rom_br;
    logic [PHASE_W-1:0] rom_bi;

    assign adv = phase_ready | ~valid_q;
    // en only gates the start of a frame; a frame in progress always completes.
    assign issue = adv & ((k_q != '0) | en);

    always_comb begin
        k_d    = k_q;
        p_d    = p_q;
        step_d = step_q;
        if (issue) begin
            if (k_q == K_LAST) begin
                k_d    = '0;
                p_d    = '0;
                step_d = step_q + D_STEP;   // wraps mod N (N is a power of two)
            end else begin
                k_d = k_q + 1'b1;
                p_d = p_q + step_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q        <= '0;
            p_q        <= '0;
            step_q     <= '0;
            s0_valid_q <= 1'b0;
            s0_k_q     <= '0;
            s0_p_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_k_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            idx_q      <= '0;
            br_q       <= '0;
            bi_q       <= '0;
        end else begin
            k_q    <= k_d;
            p_q    <= p_d;
            step_q <= step_d;
            if (adv) begin
                s0_valid_q <= issue;
                s0_k_q     <= k_q;
                s0_p_q     <= p_q;
                s1_valid_q <= s0_valid_q;
                s1_k_q     <= s0_k_q;
                valid_q    <= s1_valid_q;
                last_q     <= s1_valid_q & (s1_k_q == K_LAST);
                idx_q      <= s1_valid_q ? s1_k_q : '0;
                br_q       <= s1_valid_q ? rom_br : '0;
                bi_q       <= s1_valid_q ? rom_bi : '0;
            end
        end
    end

    phase_lut_rom #(
        .N (FFT_LEN),
        .W (PHASE_W),
        .F (PHASE_F)
    ) u_rom (
        .clk     (clk),
        .rd_en_i (adv),
        .addr_i  (s0_p_q),
        .br_o    (rom_br),
        .bi_o    (rom_bi)
    );

    assign phase_valid = valid_q;
    assign phase_last  = last_q;
    assign bin_idx     = idx_q;
    assign br          = br_q;
    assign bi          = bi_q;

endmodule

// File: tb/tb_phase_rotation_gen.sv
module tb_phase_rotation_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic ready = 1'b1;

    logic        valid, last;
    logic [15:0] br, bi;
    logic [2:0]  idx;
    logic        valid1, last1;
    logic [15:0] br1, bi1;
    logic [2:0]  idx1;

    always #5 clk = ~clk;

    phase_rotation_gen #(.FFT_LEN(8), .DEC_FAC(6), .PHASE_W(16), .PHASE_F(15)) dut (
        .clk(clk), .rst(rst), .en(en), .phase_ready(ready),
        .phase_valid(valid), .br(br), .bi(bi), .phase_last(last), .bin_idx(idx)
    );

    phase_rotation_gen #(.FFT_LEN(8), .DEC_FAC(1), .PHASE_W(16), .PHASE_F(15)) dut1 (
        .clk(clk), .rst(rst), .en(en), .phase_ready(ready),
        .phase_valid(valid1), .br(br1), .bi(bi1), .phase_last(last1), .bin_idx(idx1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_m = 0;
    int exp_k = 0;
    int frames_done = 0;
    int n_words = 0;
    int last_xfer_k = -1;
    int mark;

    logic [15:0] f1_br [8] = '{16'h7FFF, 16'h0000, 16'h8000, 16'h0000,
                               16'h7FFF, 16'h0000, 16'h8000, 16'h0000};
    logic [15:0] f1_bi [8] = '{16'h0000, 16'h7FFF, 16'h0000, 16'h8000,
                               16'h0000, 16'h7FFF, 16'h0000, 16'h8000};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference twiddle: quantised straight from the math definition.
    function automatic logic [15:0] ref_val(input int n, input int p, input bit want_bi);
        real a, x, s, r;
        int  v;
        a = 2.0 * 3.141592653589793 * real'(p) / real'(n);
        x = want_bi ? -$sin(a) : $cos(a);
        s = x * 32768.0;
        r = (s >= 0.0) ? $floor(s + 0.5) : $ceil(s - 0.5);
        v = $rtoi(r);
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    function automatic logic [67:0] snapshot();
        return {br, bi, br1, bi1, last, idx};
    endfunction

    task automatic on_xfer();
        int p, p1;
        p  = (exp_k * exp_m * 6) % 8;
        p1 = (exp_k * exp_m) % 8;
        $display("xfer m=%0d k=%0d p=%0d br=%h bi=%h last=%0d | D1 p=%0d br=%h bi=%h",
                 exp_m, exp_k, p, br, bi, last, p1, br1, bi1);
        check("br", br, ref_val(8, p, 1'b0));
        check("bi", bi, ref_val(8, p, 1'b1));
        check("bin_idx", idx, exp_k);
        check("last", last, (exp_k == 7));
        check("d1_valid", valid1, 1'b1);
        check("d1_br", br1, ref_val(8, p1, 1'b0));
        check("d1_bi", bi1, ref_val(8, p1, 1'b1));
        if (exp_m % 4 == 0) begin
            check("f0_br", br, 16'h7FFF);
            check("f0_bi", bi, 16'h0000);
        end
        if (exp_m == 1) begin
            check("f1_br", br, f1_br[exp_k]);
            check("f1_bi", bi, f1_bi[exp_k]);
            if (exp_k == 1) begin
                check("d1_f1k1_br", br1, 16'h5A82);
                check("d1_f1k1_bi", bi1, 16'hA57E);
            end
        end
        if (exp_m == 3 && exp_k == 1) begin
            check("f3k1_br", br, 16'h0000);
            check("f3k1_bi", bi, 16'h8000);
        end
        last_xfer_k = exp_k;
        n_words++;
        exp_k++;
        if (exp_k == 8) begin
            exp_k = 0;
            exp_m++;
            frames_done++;
        end
    endtask

    // One clock: account for a transfer at the coming edge, then check holds.
    task automatic tick();
        logic        stall;
        logic [67:0] snap;
        stall = valid & ~ready;
        snap  = snapshot();
        last_xfer_k = -1;
        if (valid && ready) on_xfer();
        @(posedge clk);
        #1;
        if (stall) check("hold", {valid, snapshot()}, {1'b1, snap});
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget && frames_done < target; i++) tick();
        check("frames_reached", frames_done, target);
    endtask

    initial begin
        // Reset state
        #2 rst = 1'b1;
        #1;
        check("rst_valid", valid, 1'b0);
        check("rst_br", br, 16'h0000);
        check("rst_bi", bi, 16'h0000);
        check("rst_idx", idx, 3'd0);
        check("rst_last", last, 1'b0);
        tick();
        tick();
        check("rst_valid_clk", valid, 1'b0);
        rst = 1'b0;
        tick();

        // Latency: en raised right after an edge, first word after three edges
        en = 1'b1;
        tick();
        check("lat_e1", valid, 1'b0);
        tick();
        check("lat_e2", valid, 1'b0);
        tick();
        check("lat_e3", valid, 1'b1);
        check("lat_idx", idx, 3'd0);

        // Frames 0..4 at full rate
        wait_frames(5, 100);

        // Randomised backpressure
        for (int i = 0; i < 200; i++) begin
            ready = 1'($urandom_range(0, 1));
            tick();
        end
        ready = 1'b1;

        // en dropped once bin 3 has been delivered: the frame still completes
        for (int i = 0; i < 60; i++) begin
            tick();
            if (last_xfer_k == 3) break;
        end
        check("saw_k3", last_xfer_k, 3);
        en = 1'b0;
        mark = n_words;
        for (int i = 0; i < 20; i++) tick();
        check("tail_words", n_words - mark, 4);
        check("tail_k", exp_k, 0);
        check("idle_valid", valid, 1'b0);
        tick();
        check("idle_valid2", valid, 1'b0);

        // Re-enable continues with the next frame number
        en = 1'b1;
        wait_frames(frames_done + 2, 60);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 60; i++) begin
            tick();
            if (last_xfer_k == 4) break;
        end
        check("saw_k4", last_xfer_k, 4);
        rst = 1'b1;
        #1;
        check("arst_valid", valid, 1'b0);
        check("arst_br", br, 16'h0000);
        check("arst_idx", idx, 3'd0);
        check("arst_valid_d1", valid1, 1'b0);
        exp_m = 0;
        exp_k = 0;
        tick();
        tick();
        rst = 1'b0;
        wait_frames(frames_done + 2, 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
